// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_pkg
//  Description : Shared vector-unit definitions. Holds the default element
//                width and lane count used by both the load-side buffer and
//                the transmit-side serialiser, the element word type and the
//                transmit FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    // Default element/stream word width and maximum vector length.
    localparam int VEC_BITS = 8;
    localparam int VEC_N    = 64;

    typedef logic [VEC_BITS-1:0] vec_word_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_LEN  = 2'd1,
        SEND_DATA = 2'd2,
        FINISH    = 2'd3
    } tx_state_e;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : vec_stream_tx
//  Description : Snapshots a parallel result vector and its length, then
//                serialises it onto a BITS-wide valid/ready stream: the
//                (clamped) length word first, then elements 0..len-1.
//                All outputs are registered.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                start    - transmit request, sampled only in IDLE
//                vec_in   - parallel source vector, lane i = element i
//                vec_len  - requested element count (clamped to N)
//                tx_data  - stream word
//                tx_valid - tx_data holds a valid word
//                tx_ready - downstream accepts the current word
//                busy     - frame in progress
//                done     - one-cycle pulse after the final transfer
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_stream_tx
    import vec_pkg::*;
#(
    parameter int BITS = VEC_BITS,
    parameter int N    = VEC_N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] vec_in [N-1:0],
    input  logic [BITS-1:0] vec_len,
    output logic [BITS-1:0] tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic            done
);

    localparam int c_IDX_W  = $clog2(N) + 1;
    localparam int c_ADDR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    tx_state_e           r_state;
    tx_state_e           w_state_nxt;
    logic [c_IDX_W-1:0]  r_index;
    logic [c_IDX_W-1:0]  r_len;
    logic [BITS-1:0]     r_snap [N-1:0];

    logic [c_IDX_W-1:0]  w_index_nxt;
    logic [BITS-1:0]     w_data_nxt;
    logic                w_valid_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                w_xfer;
    logic                w_last;
    logic                w_capture;
    logic [31:0]         w_len_req;
    logic [c_IDX_W-1:0]  w_len_eff;
    logic [c_ADDR_W-1:0] w_rd_addr;

    assign w_xfer    = tx_valid && tx_ready;
    assign w_last    = (r_index == (r_len - c_IDX_ONE));
    assign w_capture = (r_state == IDLE) && start;

    // Clamp in a 32-bit domain so the comparison is correct for any BITS/N mix.
    assign w_len_req = 32'(vec_len);
    assign w_len_eff = (w_len_req > 32'(N)) ? c_IDX_W'(N) : c_IDX_W'(vec_len);

    // Address of the element presented after the current one is accepted.
    assign w_rd_addr = r_index[c_ADDR_W-1:0] + c_ADDR_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SEND_LEN;
                end
            end
            SEND_LEN: begin
                if (w_xfer) begin
                    w_state_nxt = (r_len == '0) ? FINISH : SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. Outputs only change on a transfer or
    // on start, so tx_valid and tx_data hold through any stall.
    // ------------------------------------------------------------------
    always_comb begin
        w_index_nxt = r_index;
        w_data_nxt  = tx_data;
        w_valid_nxt = tx_valid;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_index_nxt = '0;
                    w_data_nxt  = BITS'(w_len_eff);
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            SEND_LEN: begin
                if (w_xfer) begin
                    if (r_len == '0) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_index_nxt = '0;
                        w_data_nxt  = r_snap[0];
                    end
                end
            end
            SEND_DATA: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_index_nxt = r_index + c_IDX_ONE;
                        w_data_nxt  = r_snap[w_rd_addr];
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_index  <= '0;
            r_len    <= '0;
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            tx_data  <= w_data_nxt;
            tx_valid <= w_valid_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            r_index  <= w_index_nxt;
            // Snapshot only on an accepted start so vec_in may change freely
            // for the rest of the frame.
            if (w_capture) begin
                r_len  <= w_len_eff;
                r_snap <= vec_in;
            end
        end
    end

endmodule : vec_stream_tx
`default_nettype wire

// File: tb/tb_vec_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_stream_tx
//  Description : Self-checking bench for vec_stream_tx. Each frame's expected
//                word list is built from the vector contents and length
//                (clamped length word, then the elements) and compared
//                against the observed transfers, along with stall stability,
//                busy/done framing and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_stream_tx;

    localparam int BITS = 8;
    localparam int N    = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [BITS-1:0] vec_in [N-1:0];
    logic [BITS-1:0] vec_len = '0;
    logic [BITS-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    vec_stream_tx #(.BITS(BITS), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vec_in   (vec_in),
        .vec_len  (vec_len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) vec_in[i] = 8'($urandom);
    endtask

    // Drives one frame and checks every observed word against the list
    // derived from the vector and the clamped length.
    task automatic run_frame(input int len, input int mode, input bit mid_start,
                             input bit finish_start, input string name);
        logic [BITS-1:0] exp_q [$];
        int              n_words;
        int              k = 0;
        bit              prev_stall = 0;
        logic [BITS-1:0] prev_data = '0;
        bit              finished = 0;

        n_words = (len > N) ? N : len;
        exp_q.push_back(8'(n_words));
        for (int i = 0; i < n_words; i++) exp_q.push_back(vec_in[i]);

        @(negedge clk);
        start    = 1'b1;
        vec_len  = 8'(len);
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;

        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s first_word: valid=%b busy=%b, required valid=1 busy=1",
                     name, tx_valid, busy);
        end

        for (int cyc = 0; cyc < 800 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (mid_start && cyc == 2) begin
                start   = 1'b1;
                vec_len = 8'($urandom_range(1, 255));
                fill_random();
            end
            if (mid_start && cyc == 3) start = 1'b0;
            tx_ready = rdy(mode, cyc);

            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL %s stall_hold: valid=%b data=%0h, required valid=1 data=%0h",
                             name, tx_valid, tx_data, prev_data);
                end
            end

            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s in_frame: busy=%b done=%b, required busy=1 done=0",
                         name, busy, done);
            end

            if (tx_valid === 1'b1 && tx_ready) begin
                checks++;
                if (k >= exp_q.size()) begin
                    errors++;
                    $display("FAIL %s extra_word: got %0h beyond %0d words",
                             name, tx_data, exp_q.size());
                end else if (tx_data !== exp_q[k]) begin
                    errors++;
                    $display("FAIL %s word%0d: got %0h, required %0h",
                             name, k, tx_data, exp_q[k]);
                end
                k++;
                if (k == exp_q.size()) finished = 1;
            end

            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d of %0d words seen", name, k, exp_q.size());
        end

        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s finish: done=%b busy=%b valid=%b, required 1 0 0",
                     name, done, busy, tx_valid);
        end
        if (finish_start) start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: done=%b busy=%b valid=%b, required 0 0 0",
                     name, done, busy, tx_valid);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b done=%b data=%0h, required all 0",
                     tx_valid, busy, done, tx_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b busy=%b done=%b, required all 0",
                     tx_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) vec_in[i] = 8'(i + 10);
        run_frame(4, 0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        for (int i = 0; i < N; i++) vec_in[i] = 8'(i + 10);
        run_frame(4, 1, 1'b0, 1'b0, "stall");
        fill_random();
        run_frame(9, 1, 1'b0, 1'b1, "stall_rand");
    endtask

    task automatic test_lengths();
        fill_random();
        run_frame(0, 0, 1'b0, 1'b0, "len_zero");
        fill_random();
        run_frame(200, 0, 1'b0, 1'b0, "len_clamp");
        fill_random();
        run_frame(64, 1, 1'b0, 1'b0, "len_max");
    endtask

    task automatic test_mid_start();
        fill_random();
        run_frame(6, 0, 1'b1, 1'b0, "mid_start");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            fill_random();
            run_frame($urandom_range(0, 80), $urandom_range(0, 2),
                      1'b0, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_midframe();
        fill_random();
        @(negedge clk);
        start    = 1'b1;
        vec_len  = 8'd10;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b done=%b data=%0h, required all 0",
                     tx_valid, busy, done, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet: valid=%b done=%b busy=%b, required 0 0 0",
                         tx_valid, done, busy);
            end
        end
        fill_random();
        run_frame(2, 0, 1'b0, 1'b0, "post_reset");
    endtask

    initial begin
        for (int i = 0; i < N; i++) vec_in[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_lengths();
        test_mid_start();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vec_stream_tx
`default_nettype wire

// File: doc/vec_stream_tx.md
Name: vec_stream_tx

Overview:
- Transmit-side counterpart of the immediate vector load path.
- Snapshots a parallel result vector (N lanes of BITS) plus its length.
- Serialises it onto a BITS-wide valid/ready byte stream toward the host interface: the length word first, then elements 0..len-1.
- Lets the Python HAL read back vector-unit results using the same framing it uses to load immediates.

Parameters:
- BITS, 8, element and stream word width.
- N, 64, maximum vector length (lane count).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to transmit the vector currently on vec_in/vec_len; sampled only in IDLE.
- vec_in  in  BITS x [N-1:0]  parallel source vector (unpacked array, lane i = element i).
- vec_len  in  BITS  requested element count.
- tx_data  out  BITS  stream word.
- tx_valid  out  1  tx_data holds a valid word.
- tx_ready  in  1  downstream accepts the word; a transfer occurs when tx_valid && tx_ready on a rising clk edge.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the final transfer.

Behaviour:
- Reset: one clock (clk); asynchronous, active-low reset (rst_n).
  - Asserting rst_n=0 immediately forces state=IDLE, tx_valid=0, busy=0, done=0, tx_data=0, index=0.
  - Snapshot registers are cleared to 0.
  - Reset mid-frame abandons the frame; no further words are emitted and no done pulse occurs.
- States: IDLE, SEND_LEN, SEND_DATA, FINISH.
- IDLE:
  - On start=1, capture all vec_in lanes into the snapshot and capture len_eff = min(vec_len, N).
  - Set index=0 and go to SEND_LEN.
  - The next cycle shows busy=1, tx_valid=1, tx_data=len_eff (zero-extended/truncated to BITS).
- SEND_LEN: hold tx_data/tx_valid until transfer.
  - On transfer, if len_eff==0 go to FINISH.
  - Otherwise present snapshot[0] and go to SEND_DATA.
- SEND_DATA: tx_data = snapshot[index].
  - On transfer, if index == len_eff-1 go to FINISH with tx_valid=0.
  - Otherwise index+1 and present the next element the following cycle.
  - No bubbles: with tx_ready held high, one word per cycle.
- FINISH: for one cycle, done=1 and busy drops to 0; then return to IDLE. A start in the FINISH cycle is ignored.
- Handshake rules:
  - tx_valid never deasserts without a transfer.
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid does not depend combinationally on tx_ready.
- start while busy: ignored. The snapshot is not modified, so vec_in may change freely after the start cycle.
- Lengths:
  - vec_len > N is clamped to N, and the transmitted length word is the clamped value.
  - vec_len = 0 emits exactly one word (0) then done.
- index width is $clog2(N)+1; comparisons use len_eff at that width.
- Latency: start at edge k -> first word valid after edge k. A frame of L elements with tx_ready=1 completes its last transfer at edge k+L+1, and done is high for the following cycle.
- All outputs are registered.

Decomposition:
- Shared package vec_pkg:
  - BITS and N defaults (shared with the load-side buffer).
  - typedef vec_word_t (logic [BITS-1:0]).
  - typedef tx_state_e enum {IDLE, SEND_LEN, SEND_DATA, FINISH}.
- Single module; no sub-module. The snapshot is a plain register array inside vec_stream_tx.

Test Plan:
- Reset, then start with vec_len=4, vec_in[i]=i+10, tx_ready=1 -> words 4,10,11,12,13 on consecutive cycles; done pulses once the cycle after word 13; busy is low afterwards.
- Same frame with tx_ready toggling 1,0,0,1,... -> identical word sequence; tx_data stable across each stall; no duplicated or dropped words.
- vec_len=0 -> exactly one transfer carrying 0, then done; vec_len=200 with N=64 -> length word 64, then 64 elements, then done.
- start pulsed again mid-frame, with vec_in and vec_len changed after the first start -> frame continues with the original snapshot and length; the second start has no effect.
- rst_n asserted low between edges during SEND_DATA -> tx_valid, busy and done drop to 0 immediately (before the next edge); after release, a new start with vec_len=2 produces 2,a,b cleanly.
